// File: rtl/data_mem_responder_pkg.sv
// Shared core package: datapath widths, wait-state limit and the
// responder FSM state encoding.
package core_pkg;
    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 8;
    localparam int REG_AW   = 3;
    localparam int MAX_WAIT = 15;
    localparam int CNT_W    = 4;   // wide enough for 0..MAX_WAIT

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;
endpackage

// File: rtl/data_mem_responder_if.sv
// MEM-stage data-memory request/response bundle. The pipeline side uses
// the master modport, the responder uses the slave modport.
interface data_mem_responder_if #(
    parameter int DATA_W = core_pkg::DATA_W,
    parameter int ADDR_W = core_pkg::ADDR_W
);
    logic              req_valid;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              stall;
    logic              err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, stall, err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, stall, err
    );
endinterface

// File: rtl/data_mem_responder_dmem_array.sv
// Data storage for the responder: synchronous write, registered read
// capture, whole-array clear on reset. With DMEM_PARITY_EN defined each
// word also keeps an even-parity bit that is rechecked on read capture.
module dmem_array #(
    parameter int DATA_W = core_pkg::DATA_W,
    parameter int ADDR_W = core_pkg::ADDR_W,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              perr
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic              rd_perr;

    // word storage, cleared on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[addr] <= wdata;
        end
    end

`ifdef DMEM_PARITY_EN
    logic [DEPTH-1:0] par;

    // parity bit written alongside the data word
    always_ff @(posedge clk or posedge reset) begin
        if (reset)      par       <= '0;
        else if (wr_en) par[addr] <= ^wdata;
    end

    assign rd_perr = (^mem[addr]) ^ par[addr];
`else
    assign rd_perr = 1'b0;
`endif

    // response capture: read data and parity check on reads, zero on writes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
            perr  <= 1'b0;
        end else if (rd_en) begin
            rdata <= mem[addr];
            perr  <= rd_perr;
        end else if (wr_en) begin
            rdata <= '0;
            perr  <= 1'b0;
        end
    end
endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the MEM-stage data-memory interface. Accepts one
// request at a time, waits WAIT_CYCLES, performs the access, then
// presents a single-cycle response. Optional parity checking is enabled
// with the DMEM_PARITY_EN macro (handled inside dmem_array).
module data_mem_responder
    import core_pkg::*;
#(
    parameter int DATA_W      = core_pkg::DATA_W,
    parameter int ADDR_W      = core_pkg::ADDR_W,
    parameter int DEPTH       = 2**ADDR_W,
    parameter int WAIT_CYCLES = 1      // 0..MAX_WAIT
) (
    input logic                 clk,
    input logic                 reset,
    data_mem_responder_if.slave bus
);
    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              access;
    logic [DATA_W-1:0] cap_rdata;
    logic              cap_perr;

    // the access happens on the edge that leaves the last wait state
    assign access = (state == BUSY) && (cnt == '0);

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // next state and handshake outputs
    always_comb begin
        state_nx      = state;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_nx = BUSY;
            end
            BUSY: begin
                if (cnt == '0) state_nx = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                state_nx      = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // request latch and wait-state counter; inputs only matter at accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (state == IDLE && bus.req_valid) begin
            cnt       <= CNT_W'(WAIT_CYCLES);
            lat_we    <= bus.req_we;
            lat_addr  <= bus.req_addr;
            lat_wdata <= bus.req_wdata;
        end else if (state == BUSY && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .wr_en (access & lat_we),
        .rd_en (access & ~lat_we),
        .addr  (lat_addr),
        .wdata (lat_wdata),
        .rdata (cap_rdata),
        .perr  (cap_perr)
    );

    // response data and error are only visible in the response cycle
    assign bus.rsp_rdata = bus.rsp_valid ? cap_rdata : '0;
    assign bus.err       = bus.rsp_valid & cap_perr;
    // hold the pipeline while a request is pending and not yet answered
    assign bus.stall     = bus.req_valid & ~bus.rsp_valid;
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: three instances with
// WAIT_CYCLES = 1, 0, 3. Stimulus pushes expected responses; a monitor
// pops and compares whenever rsp_valid is seen.
module tb_data_mem_responder;
    import core_pkg::*;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst [3];
    logic       rv  [3];
    logic       rwe [3];
    logic [7:0] ra  [3];
    logic [7:0] rwd [3];
    logic       rdy [3];
    logic       rspv[3];
    logic       stl [3];
    logic       er  [3];
    logic [7:0] rrd [3];

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    exp_t sb [3][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int wcyc(input int d);
        return (d == 0) ? 1 : (d == 1) ? 0 : 3;
    endfunction

    data_mem_responder_if bus [3] ();

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam int WC = (g == 0) ? 1 : (g == 1) ? 0 : 3;
        assign bus[g].req_valid = rv[g];
        assign bus[g].req_we    = rwe[g];
        assign bus[g].req_addr  = ra[g];
        assign bus[g].req_wdata = rwd[g];
        assign rdy[g]  = bus[g].req_ready;
        assign rspv[g] = bus[g].rsp_valid;
        assign stl[g]  = bus[g].stall;
        assign er[g]   = bus[g].err;
        assign rrd[g]  = bus[g].rsp_rdata;

        data_mem_responder #(.WAIT_CYCLES(WC)) u_dut (
            .clk   (clk),
            .reset (rst[g]),
            .bus   (bus[g])
        );
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // monitor: every response must match the oldest expectation, on time
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            if (!rst[d] && rspv[d]) begin
                if (sb[d].size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_rsp[%0d]: got rsp_valid, expected none", d);
                end else begin
                    e = sb[d].pop_front();
                    chk($sformatf("rdata[%0d]", d), int'(rrd[d]), int'(e.rdata));
                    chk($sformatf("err[%0d]", d), int'(er[d]), int'(e.err));
                    chk($sformatf("latency[%0d]", d), cyc, e.cyc);
                end
            end
        end
    end

    // issue one request, hold it until the response cycle like the pipeline
    task automatic do_req(input int d, input bit we, input logic [7:0] a,
                          input logic [7:0] wd, input logic [7:0] erd,
                          input bit eerr, input bit mutate);
        exp_t e;
        int   n;
        int   st;
        @(negedge clk);
        chk($sformatf("ready_idle[%0d]", d), int'(rdy[d]), 1);
        rv[d]  = 1'b1;
        rwe[d] = we;
        ra[d]  = a;
        rwd[d] = wd;
        e.rdata = erd;
        e.err   = eerr;
        e.cyc   = cyc + wcyc(d) + 2;
        sb[d].push_back(e);
        #1;
        st = stl[d] ? 1 : 0;
        n  = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (mutate && n == 1) begin
                ra[d]  = 8'h20;
                rwe[d] = 1'b1;
                rwd[d] = 8'h99;
            end
            if (rspv[d]) break;
            if (stl[d]) st++;
        end
        chk($sformatf("rsp_seen[%0d]", d), int'(rspv[d]), 1);
        chk($sformatf("stall_in_resp[%0d]", d), int'(stl[d]), 0);
        chk($sformatf("stall_cycles[%0d]", d), st, wcyc(d) + 2);
        rv[d]  = 1'b0;
        rwe[d] = 1'b0;
    endtask

    initial begin
        int n;
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1;
            rv[d]  = 1'b0;
            rwe[d] = 1'b0;
            ra[d]  = 8'h00;
            rwd[d] = 8'h00;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_ready[%0d]", d), int'(rdy[d]), 1);
            chk($sformatf("rst_rsp_valid[%0d]", d), int'(rspv[d]), 0);
            chk($sformatf("rst_stall[%0d]", d), int'(stl[d]), 0);
            chk($sformatf("rst_err[%0d]", d), int'(er[d]), 0);
            chk($sformatf("rst_rdata[%0d]", d), int'(rrd[d]), 0);
        end

        // cleared memory, then write/read with one wait state
        do_req(0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        do_req(0, 1'b1, 8'h3C, 8'hA5, 8'h00, 1'b0, 1'b0);
        do_req(0, 1'b0, 8'h3C, 8'h00, 8'hA5, 1'b0, 1'b0);

        // zero wait states, top and bottom addresses do not alias
        do_req(1, 1'b1, 8'hFF, 8'h5A, 8'h00, 1'b0, 1'b0);
        do_req(1, 1'b0, 8'hFF, 8'h00, 8'h5A, 1'b0, 1'b0);
        do_req(1, 1'b1, 8'h00, 8'h3E, 8'h00, 1'b0, 1'b0);
        do_req(1, 1'b0, 8'hFF, 8'h00, 8'h5A, 1'b0, 1'b0);
        do_req(1, 1'b0, 8'h00, 8'h00, 8'h3E, 1'b0, 1'b0);

        // request inputs changing while busy are ignored
        do_req(0, 1'b1, 8'h20, 8'h22, 8'h00, 1'b0, 1'b0);
        do_req(0, 1'b1, 8'h10, 8'h11, 8'h00, 1'b0, 1'b0);
        do_req(0, 1'b0, 8'h10, 8'h00, 8'h11, 1'b0, 1'b1);
        do_req(0, 1'b0, 8'h20, 8'h00, 8'h22, 1'b0, 1'b0);

        // three wait states, then reset in the middle of a write
        do_req(2, 1'b1, 8'h08, 8'h99, 8'h00, 1'b0, 1'b0);
        do_req(2, 1'b0, 8'h08, 8'h00, 8'h99, 1'b0, 1'b0);
        @(negedge clk);
        rv[2]  = 1'b1;
        rwe[2] = 1'b1;
        ra[2]  = 8'h08;
        rwd[2] = 8'h77;
        @(negedge clk);
        chk("busy_ready[2]", int'(rdy[2]), 0);
        @(negedge clk);
        rst[2] = 1'b1;
        rv[2]  = 1'b0;
        rwe[2] = 1'b0;
        #1;
        chk("midrst_ready[2]", int'(rdy[2]), 1);
        repeat (2) @(negedge clk);
        rst[2] = 1'b0;
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (rspv[2]) n++;
        end
        chk("midrst_no_rsp[2]", n, 0);
        do_req(2, 1'b0, 8'h08, 8'h00, 8'h00, 1'b0, 1'b0);

`ifdef DMEM_PARITY_EN
        do_req(0, 1'b1, 8'h40, 8'hC3, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        gen_dut[0].u_dut.u_array.par[8'h40] = ~gen_dut[0].u_dut.u_array.par[8'h40];
        do_req(0, 1'b0, 8'h40, 8'h00, 8'hC3, 1'b1, 1'b0);
        @(negedge clk);
        chk("err_one_cycle[0]", int'(er[0]), 0);
        do_req(0, 1'b0, 8'h3C, 8'h00, 8'hA5, 1'b0, 1'b0);
`endif

        repeat (4) @(negedge clk);
        for (int d = 0; d < 3; d++)
            chk($sformatf("sb_drained[%0d]", d), sb[d].size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
